axis_block_accumulator: RTL and testbench
=========================================

Name: axis_block_accumulator

Overview:
- Generalised AXI-Stream block reducer: consumes ACC_COUNT input samples per block and emits one reduced result per block.
- Result is selectable per block between the block sum and the power-of-two average.
- Each result is repeated REPETITIONS times on the output.
- Replaces the separate accumulator/averager/repeater chain in the per-block statistics path of the predictor pipeline.

Parameters:
DATA_WIDTH, 16, width of input samples
ACC_COUNT_LOG, 8, log2 of maximum block length; sets output growth bits
ACC_COUNT, 256, samples per block; 1 <= ACC_COUNT <= 2**ACC_COUNT_LOG
IS_SIGNED, 0, 1 = inputs two's complement (sign-extend, arithmetic shift); 0 = unsigned
REPETITIONS, 1, output beats per result; >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset; asserting it (0) immediately resets all state, deassertion takes effect on the next rising edge of clk
mode_avg  in  1  0 = sum, 1 = average; sampled on first input handshake of each block
input_valid  in  1  AXIS valid
input_ready  out  1  AXIS ready
input_data  in  DATA_WIDTH  sample
output_valid  out  1  AXIS valid
output_ready  in  1  AXIS ready
output_data  out  DATA_WIDTH+ACC_COUNT_LOG  result, right-aligned, sign- or zero-extended per IS_SIGNED
output_last  out  1  high on the final repetition beat of a result

Behaviour:
- Width: OW = DATA_WIDTH+ACC_COUNT_LOG. Each sample is extended to OW (sign if IS_SIGNED, else zero) before adding. The sum cannot overflow.
- Average mode: result = sum >> ACC_COUNT_LOG. Shift is arithmetic if IS_SIGNED, else logical, so it truncates toward minus infinity. The result is a true mean only when ACC_COUNT = 2**ACC_COUNT_LOG; otherwise it is still computed this way.
- FSM states: ACCUM, OUTPUT.
- ACCUM:
  - input_ready=1, output_valid=0.
  - Each handshake adds to acc and increments sample counter cnt (0..ACC_COUNT-1).
  - On the handshake with cnt=ACC_COUNT-1: final result (acc+sample, shifted if the latched mode=1) goes to result register; acc and cnt clear; rep counter loads 0; next state OUTPUT.
- OUTPUT:
  - input_ready=0, output_valid=1, output_data=result register (stable while stalled).
  - output_last=1 when rep=REPETITIONS-1.
  - Each output handshake increments rep. The handshake with rep=REPETITIONS-1 returns to ACCUM.
- Latency: output_valid rises the cycle after the last input handshake of a block. input_ready rises the cycle after the last output handshake (one bubble; no overlap of accumulate and output).
- ACC_COUNT=1: every input handshake produces a result; FSM alternates states.
- Mode latch:
  - mode_avg is captured on the handshake with cnt=0. Changes during the rest of the block are ignored.
  - For ACC_COUNT=1, the mode is captured and used in the same handshake.
- Backpressure: output_ready low holds OUTPUT indefinitely, with no data change. input_valid low in ACCUM just pauses counting.
- input_valid/input_data are ignored while input_ready=0.
- Reset values: input_ready=0 while rst=0; input_ready=1 from the first cycle after deassertion. output_valid=0, output_last=0, output_data=0. acc, cnt, rep and mode latch are 0; state is ACCUM.
- Reset mid-block or mid-output discards the partial sum or pending result. No beat is emitted for it.

Test Plan:
(All cases DATA_WIDTH=8, ACC_COUNT_LOG=2, ACC_COUNT=4, so OW=10.)
1. Unsigned sum, REPETITIONS=1: inputs 1,2,3,4 with mode_avg=0 -> one beat output_data=10 (0x00A), output_last=1; input_ready=0 for exactly that output cycle when output_ready=1.
2. Unsigned full-scale: 255 x4 -> sum 1020 (0x3FC), no overflow. Same block with mode_avg=1 -> 255 (0x0FF).
3. Signed average, IS_SIGNED=1: inputs -1,-2,-3,-4 with mode_avg=1 -> 0x3FD (-3, floor of -2.5). With mode_avg=0 -> 0x3F6 (-10).
4. REPETITIONS=3, output_ready toggling 1,0,1,0,1: inputs 5,5,5,5 sum -> three beats of 20 (0x014). output_last only on the third beat. output_data stable during stalls. input_ready=0 until the cycle after the third handshake.
5. mode_avg=0 at the first sample, then switched to 1 before samples 2-4 (inputs 4,4,4,4) -> output 16 (sum, not 4).
6. Assert rst after 2 of 4 samples (7,7), deassert, then feed 1,1,1,1 sum -> single output 4. No beat reflecting the 7s. All outputs are at reset values while rst=0.

Source files
------------

// File: rtl/axis_block_accumulator.sv
// ----------------------------------------------------------------------------
// axis_block_accumulator
//
// Purpose:
//   AXI-Stream block reducer. Consumes ACC_COUNT samples per block and emits
//   one reduced result per block: either the block sum or the power-of-two
//   average (sum >> ACC_COUNT_LOG). Each result is presented REPETITIONS
//   times on the output stream. Accumulation and output never overlap.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   mode_avg      in   0 = sum, 1 = average; latched on first sample of a block
//   input_valid   in   AXIS valid for input samples
//   input_ready   out  AXIS ready for input samples
//   input_data    in   sample, DATA_WIDTH bits
//   output_valid  out  AXIS valid for results
//   output_ready  in   AXIS ready for results
//   output_data   out  result, DATA_WIDTH+ACC_COUNT_LOG bits, right-aligned
//   output_last   out  high on the final repetition beat of a result
// ----------------------------------------------------------------------------
module axis_block_accumulator #(
    parameter int DATA_WIDTH    = 16,
    parameter int ACC_COUNT_LOG = 8,
    parameter int ACC_COUNT     = 256,
    parameter int IS_SIGNED     = 0,
    parameter int REPETITIONS   = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                mode_avg,
    input  logic                                input_valid,
    output logic                                input_ready,
    input  logic [DATA_WIDTH-1:0]               input_data,
    output logic                                output_valid,
    input  logic                                output_ready,
    output logic [DATA_WIDTH+ACC_COUNT_LOG-1:0] output_data,
    output logic                                output_last
);

    localparam int OW    = DATA_WIDTH + ACC_COUNT_LOG;
    localparam int CNT_W = $clog2(ACC_COUNT + 1);
    localparam int REP_W = $clog2(REPETITIONS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_COUNT - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPETITIONS - 1);

    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    // Widen a sample to the accumulator width: sign-extend for two's
    // complement inputs, zero-extend otherwise.
    function automatic logic signed [OW-1:0] extend_sample(input logic [DATA_WIDTH-1:0] d);
        logic                 sign_bit;
        logic signed [OW-1:0] r;
        sign_bit = (IS_SIGNED != 0) ? d[DATA_WIDTH-1] : 1'b0;
        r = {OW{sign_bit}};
        r[DATA_WIDTH-1:0] = d;
        return r;
    endfunction

    // Power-of-two average; truncates toward minus infinity in both modes.
    function automatic logic signed [OW-1:0] avg_shift(input logic signed [OW-1:0] s);
        if (IS_SIGNED != 0) begin
            return s >>> ACC_COUNT_LOG;
        end
        return $signed($unsigned(s) >> ACC_COUNT_LOG);
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_run;
    logic signed [OW-1:0] r_acc;
    logic signed [OW-1:0] r_result;
    logic [CNT_W-1:0]     r_cnt;
    logic [REP_W-1:0]     r_rep;
    logic                 r_mode;

    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_mode;
    logic                 w_last_in;
    logic                 w_last_out;
    logic signed [OW-1:0] w_sum;

    assign w_in_hs    = input_valid && input_ready;
    assign w_out_hs   = output_valid && output_ready;
    // First sample of a block uses the live mode so ACC_COUNT=1 works.
    assign w_mode     = (r_cnt == '0) ? mode_avg : r_mode;
    assign w_sum      = r_acc + extend_sample(input_data);
    assign w_last_in  = w_in_hs && (r_cnt == CNT_LAST);
    assign w_last_out = w_out_hs && (r_rep == REP_LAST);
    assign output_data = r_result;

    // ---- state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- next state and handshake outputs ----
    always_comb begin
        w_state_nxt  = r_state;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        output_last  = 1'b0;
        case (r_state)
            ACCUM: begin
                // r_run holds ready low until the first edge after reset release.
                input_ready = r_run;
                if (w_last_in) begin
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                output_valid = 1'b1;
                output_last  = (r_rep == REP_LAST);
                if (w_last_out) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // ---- accumulator, counters and result register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run    <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_rep    <= '0;
            r_mode   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_in_hs) begin
                if (r_cnt == '0) begin
                    r_mode <= mode_avg;
                end
                if (w_last_in) begin
                    r_result <= w_mode ? avg_shift(w_sum) : w_sum;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_rep    <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_out_hs) begin
                if (w_last_out) begin
                    r_rep <= '0;
                end else begin
                    r_rep <= r_rep + REP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_block_accumulator.sv
// ----------------------------------------------------------------------------
// tb_axis_block_accumulator
//
// Three instances (DATA_WIDTH=8, ACC_COUNT_LOG=2, ACC_COUNT=4):
//   0: unsigned, REPETITIONS=1
//   1: signed,   REPETITIONS=1
//   2: unsigned, REPETITIONS=3
// A behavioural model turns accepted samples into a queue of expected output
// beats; a compare process checks every instance every cycle against it.
// Directed tests additionally pin captured beats to hand-computed literals.
// ----------------------------------------------------------------------------
module tb_axis_block_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode [3];
    logic       iv   [3];
    logic       ir   [3];
    logic [7:0] id   [3];
    logic       ov   [3];
    logic       ordy [3];
    logic [9:0] od   [3];
    logic       ol   [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axis_block_accumulator #(.DATA_WIDTH(8), .ACC_COUNT_LOG(2), .ACC_COUNT(4),
                             .IS_SIGNED(0), .REPETITIONS(1)) u_uns (
        .clk(clk), .rst(rst), .mode_avg(mode[0]), .input_valid(iv[0]),
        .input_ready(ir[0]), .input_data(id[0]), .output_valid(ov[0]),
        .output_ready(ordy[0]), .output_data(od[0]), .output_last(ol[0]));

    axis_block_accumulator #(.DATA_WIDTH(8), .ACC_COUNT_LOG(2), .ACC_COUNT(4),
                             .IS_SIGNED(1), .REPETITIONS(1)) u_sgn (
        .clk(clk), .rst(rst), .mode_avg(mode[1]), .input_valid(iv[1]),
        .input_ready(ir[1]), .input_data(id[1]), .output_valid(ov[1]),
        .output_ready(ordy[1]), .output_data(od[1]), .output_last(ol[1]));

    axis_block_accumulator #(.DATA_WIDTH(8), .ACC_COUNT_LOG(2), .ACC_COUNT(4),
                             .IS_SIGNED(0), .REPETITIONS(3)) u_rep (
        .clk(clk), .rst(rst), .mode_avg(mode[2]), .input_valid(iv[2]),
        .input_ready(ir[2]), .input_data(id[2]), .output_valid(ov[2]),
        .output_ready(ordy[2]), .output_data(od[2]), .output_last(ol[2]));

    function automatic int is_sgn(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int reps(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic int floor_div4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_sum   [3];
    int         m_cnt   [3];
    logic       m_mode  [3];
    logic [9:0] e_d     [3][16];
    logic       e_l     [3][16];
    int         e_head  [3];
    int         e_n     [3];
    bit         running = 1'b0;

    // Snapshot of what will be sampled at the next rising edge.
    logic       s_in_hs [3];
    logic       s_out_hs[3];
    logic [7:0] s_d     [3];
    logic       s_m     [3];

    // DUT beats accepted by the sink, for literal checks.
    logic [9:0] cap_d   [3][64];
    logic       cap_l   [3][64];
    int         cap_n   [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_mode[i] = 1'b0;
            e_head[i] = 0; e_n[i] = 0; cap_n[i] = 0;
            s_in_hs[i] = 1'b0; s_out_hs[i] = 1'b0; s_d[i] = '0; s_m[i] = 1'b0;
            mode[i] = 1'b0; iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b1;
        end
    end

    always @(posedge clk or negedge rst) begin
        int r;
        if (!rst) begin
            running = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_mode[i] = 1'b0;
                e_head[i] = 0; e_n[i] = 0;
                s_in_hs[i] = 1'b0; s_out_hs[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s_out_hs[i] && e_n[i] > 0) begin
                    e_head[i] = (e_head[i] + 1) % 16;
                    e_n[i]--;
                end
                if (s_in_hs[i]) begin
                    if (m_cnt[i] == 0) m_mode[i] = s_m[i];
                    m_sum[i] += (is_sgn(i) != 0) ? int'($signed(s_d[i])) : int'(s_d[i]);
                    m_cnt[i]++;
                    if (m_cnt[i] == 4) begin
                        r = m_mode[i] ? floor_div4(m_sum[i]) : m_sum[i];
                        for (int k = 0; k < reps(i); k++) begin
                            e_d[i][(e_head[i] + e_n[i]) % 16] = 10'(r);
                            e_l[i][(e_head[i] + e_n[i]) % 16] = (k == reps(i) - 1);
                            e_n[i]++;
                        end
                        m_sum[i] = 0;
                        m_cnt[i] = 0;
                    end
                end
            end
            running = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                chk($sformatf("rst_in_ready[%0d]", i), int'(ir[i]), 0);
                chk($sformatf("rst_out_valid[%0d]", i), int'(ov[i]), 0);
                chk($sformatf("rst_out_last[%0d]", i), int'(ol[i]), 0);
                chk($sformatf("rst_out_data[%0d]", i), int'(od[i]), 0);
            end else begin
                chk($sformatf("out_valid[%0d]", i), int'(ov[i]), int'(e_n[i] != 0));
                chk($sformatf("in_ready[%0d]", i), int'(ir[i]), int'(running && e_n[i] == 0));
                if (e_n[i] != 0) begin
                    chk($sformatf("out_data[%0d]", i), int'(od[i]), int'(e_d[i][e_head[i]]));
                    chk($sformatf("out_last[%0d]", i), int'(ol[i]), int'(e_l[i][e_head[i]]));
                end
                if (ov[i] && ordy[i] && cap_n[i] < 64) begin
                    cap_d[i][cap_n[i]] = od[i];
                    cap_l[i][cap_n[i]] = ol[i];
                    cap_n[i]++;
                end
            end
            s_in_hs[i]  = iv[i] && ir[i] && rst;
            s_out_hs[i] = ov[i] && ordy[i] && rst;
            s_d[i]      = id[i];
            s_m[i]      = mode[i];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int i, input logic [7:0] d, input logic m);
        int k;
        @(negedge clk);
        iv[i] = 1'b1; id[i] = d; mode[i] = m;
        k = 0;
        while (!ir[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ir[i]) chk($sformatf("send_timeout[%0d]", i), 0, 1);
        @(posedge clk);
    endtask

    task automatic idle_input(input int i);
        @(negedge clk);
        iv[i] = 1'b0;
    endtask

    task automatic wait_drained(input int i);
        int k;
        k = 0;
        while ((e_n[i] != 0 || !ir[i]) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("drain_timeout[%0d]", i), int'(e_n[i] == 0 && ir[i]), 1);
    endtask

    task automatic send_block(input int i, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input logic m);
        send(i, a, m); send(i, b, m); send(i, c, m); send(i, d, m);
        idle_input(i);
        wait_drained(i);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int k;
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: unsigned sum 1,2,3,4 -> 10
        base = cap_n[0];
        send_block(0, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        chk("t1_beats", cap_n[0] - base, 1);
        chk("t1_data", int'(cap_d[0][base]), 'h00A);
        chk("t1_last", int'(cap_l[0][base]), 1);

        // 2: full-scale unsigned, sum then average
        base = cap_n[0];
        send_block(0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send_block(0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        chk("t2_beats", cap_n[0] - base, 2);
        chk("t2_sum", int'(cap_d[0][base]), 'h3FC);
        chk("t2_avg", int'(cap_d[0][base + 1]), 'h0FF);

        // 3: signed -1,-2,-3,-4 average then sum
        base = cap_n[1];
        send_block(1, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 1'b1);
        send_block(1, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 1'b0);
        chk("t3_beats", cap_n[1] - base, 2);
        chk("t3_avg", int'(cap_d[1][base]), 'h3FD);
        chk("t3_sum", int'(cap_d[1][base + 1]), 'h3F6);

        // 4: three repetitions with output_ready toggling
        base = cap_n[2];
        ordy[2] = 1'b0;
        send(2, 8'd5, 1'b0); send(2, 8'd5, 1'b0); send(2, 8'd5, 1'b0); send(2, 8'd5, 1'b0);
        idle_input(2);
        k = 0;
        while (!ov[2] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t4_valid_timeout", int'(ov[2]), 1);
        for (int j = 0; j < 5; j++) begin
            ordy[2] = pat[j];
            @(negedge clk);
        end
        ordy[2] = 1'b1;
        wait_drained(2);
        chk("t4_beats", cap_n[2] - base, 3);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t4_data%0d", j), int'(cap_d[2][base + j]), 'h014);
            chk($sformatf("t4_last%0d", j), int'(cap_l[2][base + j]), (j == 2) ? 1 : 0);
        end

        // 5: mode switches after the first sample; sum is kept
        base = cap_n[0];
        send(0, 8'd4, 1'b0); send(0, 8'd4, 1'b1); send(0, 8'd4, 1'b1); send(0, 8'd4, 1'b1);
        idle_input(0);
        wait_drained(0);
        chk("t5_beats", cap_n[0] - base, 1);
        chk("t5_data", int'(cap_d[0][base]), 16);

        // 6: reset mid-block discards the partial sum
        base = cap_n[0];
        send(0, 8'd7, 1'b0); send(0, 8'd7, 1'b0);
        @(negedge clk);
        iv[0] = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_block(0, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        chk("t6_beats", cap_n[0] - base, 1);
        chk("t6_data", int'(cap_d[0][base]), 4);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
